// File: rtl/spi_load_master.sv
// SPI mode-0 master that turns single-word read/write requests into the load/debug slave's byte protocol.
// Define SPI_LOAD_MASTER_READ_EN to build the dummy/read-data path; without it, reads are rejected with rsp_err_o.
module spi_load_master #(
   parameter int CLK_DIV      = 2,
   parameter int DUMMY_CYCLES = 32,
   parameter int CS_IDLE      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        spi_sck_o,
   output logic        spi_csn_o,
   output logic        spi_sdo_o,
   input  logic        spi_sdi_i
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_GAP, S_REJECT
   } state_t;

   localparam logic [7:0]       CMD_WRITE  = 8'h02;
   localparam logic [7:0]       CMD_READ   = 8'h0B;
   localparam logic [7:0]       DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [5:0]       DUMMY_LAST = 6'(DUMMY_CYCLES - 1);
   localparam int               GAP_W      = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(CS_IDLE - 1);

   state_t            state;
   state_t            state_next;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       shreg;
   logic [5:0]        bit_cnt;
   logic [7:0]        div_cnt;
   logic              sck_q;
   logic [GAP_W-1:0]  gap_cnt;
   logic              accept;
   logic              spi_active;
   logic              tick;
   logic              sck_fall;
   logic              field_done;
`ifdef SPI_LOAD_MASTER_READ_EN
   logic              wr_q;
   logic              sck_rise;
   logic [31:0]       rx_sh;
   logic [31:0]       rdata_q;
`else
   logic              unused_sdi;
`endif

   assign accept     = (state == S_IDLE) && req_valid_i;
   assign spi_active = state inside {S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA};
   assign tick       = spi_active && (div_cnt == DIV_LAST);
   assign sck_fall   = tick && sck_q;
   assign field_done = sck_fall && (bit_cnt == 6'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (req_valid_i) begin
`ifdef SPI_LOAD_MASTER_READ_EN
               state_next = S_CMD;
`else
               state_next = req_write_i ? S_CMD : S_REJECT;
`endif
            end
         end
         S_CMD:   if (field_done) state_next = S_ADDR;
         S_ADDR: begin
            if (field_done) begin
`ifdef SPI_LOAD_MASTER_READ_EN
               state_next = wr_q ? S_WDATA : S_DUMMY;
`else
               state_next = S_WDATA;
`endif
            end
         end
         S_WDATA: if (field_done) state_next = S_GAP;
`ifdef SPI_LOAD_MASTER_READ_EN
         S_DUMMY: if (field_done) state_next = S_RDATA;
         S_RDATA: if (field_done) state_next = S_GAP;
`endif
         S_GAP:    if (gap_cnt == '0) state_next = S_IDLE;
         S_REJECT: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = (state == S_IDLE);
      spi_csn_o   = !spi_active;
      rsp_valid_o = ((state == S_GAP) && (gap_cnt == '0)) || (state == S_REJECT);
      rsp_err_o   = (state == S_REJECT);
   end

   assign spi_sck_o = sck_q;
   assign spi_sdo_o = shreg[31];

   // Shift on the SCK falling edge; at the end of each field load the next one chosen by state_next.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         shreg   <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         sck_q   <= 1'b0;
         gap_cnt <= '0;
`ifdef SPI_LOAD_MASTER_READ_EN
         wr_q    <= 1'b0;
`endif
      end else if (accept) begin
         addr_q  <= req_addr_i;
         wdata_q <= req_wdata_i;
         bit_cnt <= 6'd7;
         div_cnt <= '0;
         sck_q   <= 1'b0;
`ifdef SPI_LOAD_MASTER_READ_EN
         wr_q    <= req_write_i;
         shreg   <= {(req_write_i ? CMD_WRITE : CMD_READ), 24'h0};
`else
         shreg   <= req_write_i ? {CMD_WRITE, 24'h0} : 32'h0;
`endif
      end else if (spi_active) begin
         if (tick) begin
            div_cnt <= '0;
            sck_q   <= ~sck_q;
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
         if (sck_fall) begin
            if (bit_cnt == 6'd0) begin
               case (state_next)
                  S_ADDR:  begin shreg <= addr_q;  bit_cnt <= 6'd31;     end
                  S_WDATA: begin shreg <= wdata_q; bit_cnt <= 6'd31;     end
                  S_DUMMY: begin shreg <= '0;      bit_cnt <= DUMMY_LAST; end
                  S_RDATA: begin shreg <= '0;      bit_cnt <= 6'd31;     end
                  default: begin shreg <= '0;      gap_cnt <= GAP_LAST;  end
               endcase
            end else begin
               shreg   <= {shreg[30:0], 1'b0};
               bit_cnt <= bit_cnt - 6'd1;
            end
         end
      end else if (state == S_GAP) begin
         gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

`ifdef SPI_LOAD_MASTER_READ_EN
   assign sck_rise = tick && !sck_q;

   // Sample MISO on the SCK rising edge; publish the word only once the RDATA field completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sh   <= '0;
         rdata_q <= '0;
      end else begin
         if (sck_rise && (state == S_RDATA)) rx_sh <= {rx_sh[30:0], spi_sdi_i};
         if (field_done && (state == S_RDATA)) rdata_q <= rx_sh;
      end
   end

   assign rsp_rdata_o = rdata_q;
`else
   assign unused_sdi  = spi_sdi_i;
   assign rsp_rdata_o = '0;
`endif

endmodule
